// File: rtl/vxe_top.sv
// Register block with an AXI4 slave for control/status and a single-beat 64-bit
// fetch engine on master 0. Master 1 is present for interface compatibility and tied off.
module vxe_top #(
    parameter int S0_ID_WIDTH           = 7,
    parameter int M0_ID_WIDTH           = 7,
    parameter int M1_ID_WIDTH           = 7,
    parameter int MEMIF_FIFO_DEPTH_POW2 = 5
) (
    input  logic                   clk,
    input  logic                   nrst,
    output logic                   o_intr,
    // S0 slave
    input  logic [S0_ID_WIDTH-1:0] S0_AXI4_AWID,
    input  logic [11:0]            S0_AXI4_AWADDR,
    input  logic [7:0]             S0_AXI4_AWLEN,
    input  logic [2:0]             S0_AXI4_AWSIZE,
    input  logic [1:0]             S0_AXI4_AWBURST,
    input  logic                   S0_AXI4_AWLOCK,
    input  logic [3:0]             S0_AXI4_AWCACHE,
    input  logic [2:0]             S0_AXI4_AWPROT,
    input  logic                   S0_AXI4_AWVALID,
    output logic                   S0_AXI4_AWREADY,
    input  logic [31:0]            S0_AXI4_WDATA,
    input  logic [3:0]             S0_AXI4_WSTRB,
    input  logic                   S0_AXI4_WLAST,
    input  logic                   S0_AXI4_WVALID,
    output logic                   S0_AXI4_WREADY,
    output logic [S0_ID_WIDTH-1:0] S0_AXI4_BID,
    output logic [1:0]             S0_AXI4_BRESP,
    output logic                   S0_AXI4_BVALID,
    input  logic                   S0_AXI4_BREADY,
    input  logic [S0_ID_WIDTH-1:0] S0_AXI4_ARID,
    input  logic [11:0]            S0_AXI4_ARADDR,
    input  logic [7:0]             S0_AXI4_ARLEN,
    input  logic [2:0]             S0_AXI4_ARSIZE,
    input  logic [1:0]             S0_AXI4_ARBURST,
    input  logic                   S0_AXI4_ARLOCK,
    input  logic [3:0]             S0_AXI4_ARCACHE,
    input  logic [2:0]             S0_AXI4_ARPROT,
    input  logic                   S0_AXI4_ARVALID,
    output logic                   S0_AXI4_ARREADY,
    output logic [S0_ID_WIDTH-1:0] S0_AXI4_RID,
    output logic [31:0]            S0_AXI4_RDATA,
    output logic [1:0]             S0_AXI4_RRESP,
    output logic                   S0_AXI4_RLAST,
    output logic                   S0_AXI4_RVALID,
    input  logic                   S0_AXI4_RREADY,
    // M0 master
    output logic [M0_ID_WIDTH-1:0] M0_AXI4_AWID,
    output logic [39:0]            M0_AXI4_AWADDR,
    output logic [7:0]             M0_AXI4_AWLEN,
    output logic [2:0]             M0_AXI4_AWSIZE,
    output logic [1:0]             M0_AXI4_AWBURST,
    output logic                   M0_AXI4_AWLOCK,
    output logic [3:0]             M0_AXI4_AWCACHE,
    output logic [2:0]             M0_AXI4_AWPROT,
    output logic                   M0_AXI4_AWVALID,
    input  logic                   M0_AXI4_AWREADY,
    output logic [63:0]            M0_AXI4_WDATA,
    output logic [7:0]             M0_AXI4_WSTRB,
    output logic                   M0_AXI4_WLAST,
    output logic                   M0_AXI4_WVALID,
    input  logic                   M0_AXI4_WREADY,
    input  logic [M0_ID_WIDTH-1:0] M0_AXI4_BID,
    input  logic [1:0]             M0_AXI4_BRESP,
    input  logic                   M0_AXI4_BVALID,
    output logic                   M0_AXI4_BREADY,
    output logic [M0_ID_WIDTH-1:0] M0_AXI4_ARID,
    output logic [39:0]            M0_AXI4_ARADDR,
    output logic [7:0]             M0_AXI4_ARLEN,
    output logic [2:0]             M0_AXI4_ARSIZE,
    output logic [1:0]             M0_AXI4_ARBURST,
    output logic                   M0_AXI4_ARLOCK,
    output logic [3:0]             M0_AXI4_ARCACHE,
    output logic [2:0]             M0_AXI4_ARPROT,
    output logic                   M0_AXI4_ARVALID,
    input  logic                   M0_AXI4_ARREADY,
    input  logic [M0_ID_WIDTH-1:0] M0_AXI4_RID,
    input  logic [63:0]            M0_AXI4_RDATA,
    input  logic [1:0]             M0_AXI4_RRESP,
    input  logic                   M0_AXI4_RLAST,
    input  logic                   M0_AXI4_RVALID,
    output logic                   M0_AXI4_RREADY,
    // M1 master
    output logic [M1_ID_WIDTH-1:0] M1_AXI4_AWID,
    output logic [39:0]            M1_AXI4_AWADDR,
    output logic [7:0]             M1_AXI4_AWLEN,
    output logic [2:0]             M1_AXI4_AWSIZE,
    output logic [1:0]             M1_AXI4_AWBURST,
    output logic                   M1_AXI4_AWLOCK,
    output logic [3:0]             M1_AXI4_AWCACHE,
    output logic [2:0]             M1_AXI4_AWPROT,
    output logic                   M1_AXI4_AWVALID,
    input  logic                   M1_AXI4_AWREADY,
    output logic [63:0]            M1_AXI4_WDATA,
    output logic [7:0]             M1_AXI4_WSTRB,
    output logic                   M1_AXI4_WLAST,
    output logic                   M1_AXI4_WVALID,
    input  logic                   M1_AXI4_WREADY,
    input  logic [M1_ID_WIDTH-1:0] M1_AXI4_BID,
    input  logic [1:0]             M1_AXI4_BRESP,
    input  logic                   M1_AXI4_BVALID,
    output logic                   M1_AXI4_BREADY,
    output logic [M1_ID_WIDTH-1:0] M1_AXI4_ARID,
    output logic [39:0]            M1_AXI4_ARADDR,
    output logic [7:0]             M1_AXI4_ARLEN,
    output logic [2:0]             M1_AXI4_ARSIZE,
    output logic [1:0]             M1_AXI4_ARBURST,
    output logic                   M1_AXI4_ARLOCK,
    output logic [3:0]             M1_AXI4_ARCACHE,
    output logic [2:0]             M1_AXI4_ARPROT,
    output logic                   M1_AXI4_ARVALID,
    input  logic                   M1_AXI4_ARREADY,
    input  logic [M1_ID_WIDTH-1:0] M1_AXI4_RID,
    input  logic [63:0]            M1_AXI4_RDATA,
    input  logic [1:0]             M1_AXI4_RRESP,
    input  logic                   M1_AXI4_RLAST,
    input  logic                   M1_AXI4_RVALID,
    output logic                   M1_AXI4_RREADY
);

    typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA} state_e;

    localparam logic [9:0]  IDX_ID       = 10'd0;
    localparam logic [9:0]  IDX_STATUS   = 10'd1;
    localparam logic [9:0]  IDX_INTR_ACT = 10'd2;
    localparam logic [9:0]  IDX_INTR_MSK = 10'd3;
    localparam logic [9:0]  IDX_INTR_RAW = 10'd4;
    localparam logic [9:0]  IDX_PGM_LO   = 10'd5;
    localparam logic [9:0]  IDX_PGM_HI   = 10'd6;
    localparam logic [9:0]  IDX_START    = 10'd7;
    localparam logic [9:0]  IDX_DATA_LO  = 10'd8;
    localparam logic [9:0]  IDX_DATA_HI  = 10'd9;
    localparam logic [31:0] ID_VALUE     = 32'h5658_4500;

    state_e                 state_q, state_d;
    logic [1:0]             msk_q, msk_d;
    logic [1:0]             raw_q, raw_d;
    logic [28:0]            pgm_lo_q, pgm_lo_d;
    logic [7:0]             pgm_hi_q, pgm_hi_d;
    logic [39:0]            fetch_addr_q, fetch_addr_d;
    logic [63:0]            data_q, data_d;
    logic                   bvalid_q, bvalid_d;
    logic [S0_ID_WIDTH-1:0] bid_q, bid_d;
    logic                   rvalid_q, rvalid_d;
    logic [S0_ID_WIDTH-1:0] rid_q, rid_d;
    logic [31:0]            rdata_q, rdata_d;

    logic       wr_hs, rd_hs, busy, m0_arvalid, m0_rready;
    logic [9:0] wr_idx, rd_idx;
    logic [31:0] rd_val;

    assign busy   = (state_q != ST_IDLE);
    assign wr_idx = S0_AXI4_AWADDR[11:2];
    assign rd_idx = S0_AXI4_ARADDR[11:2];
    assign wr_hs  = S0_AXI4_AWVALID & S0_AXI4_WVALID & ~bvalid_q;
    assign rd_hs  = S0_AXI4_ARVALID & ~rvalid_q;

    always_comb begin
        rd_val = 32'h0;
        case (rd_idx)
            IDX_ID:       rd_val = ID_VALUE;
            IDX_STATUS:   rd_val = {31'h0, busy};
            IDX_INTR_ACT: rd_val = {30'h0, raw_q & msk_q};
            IDX_INTR_MSK: rd_val = {30'h0, msk_q};
            IDX_INTR_RAW: rd_val = {30'h0, raw_q};
            IDX_PGM_LO:   rd_val = {pgm_lo_q, 3'b000};
            IDX_PGM_HI:   rd_val = {24'h0, pgm_hi_q};
            IDX_DATA_LO:  rd_val = data_q[31:0];
            IDX_DATA_HI:  rd_val = data_q[63:32];
            default:      rd_val = 32'h0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        msk_d        = msk_q;
        raw_d        = raw_q;
        pgm_lo_d     = pgm_lo_q;
        pgm_hi_d     = pgm_hi_q;
        fetch_addr_d = fetch_addr_q;
        data_d       = data_q;
        m0_arvalid   = 1'b0;
        m0_rready    = 1'b0;

        bvalid_d = wr_hs ? 1'b1 : (S0_AXI4_BREADY ? 1'b0 : bvalid_q);
        bid_d    = wr_hs ? S0_AXI4_AWID : bid_q;
        rvalid_d = rd_hs ? 1'b1 : (S0_AXI4_RREADY ? 1'b0 : rvalid_q);
        rid_d    = rd_hs ? S0_AXI4_ARID : rid_q;
        rdata_d  = rd_hs ? rd_val : rdata_q;

        if (wr_hs) begin
            case (wr_idx)
                IDX_INTR_ACT: raw_d    = raw_q & ~S0_AXI4_WDATA[1:0];
                IDX_INTR_MSK: msk_d    = S0_AXI4_WDATA[1:0];
                IDX_PGM_LO:   pgm_lo_d = S0_AXI4_WDATA[31:3];
                IDX_PGM_HI:   pgm_hi_d = S0_AXI4_WDATA[7:0];
                default:      ;
            endcase
        end

        // The fetch address is snapshotted at START so ARADDR cannot move under ARVALID.
        case (state_q)
            ST_IDLE: begin
                if (wr_hs && (wr_idx == IDX_START)) begin
                    state_d      = ST_ADDR;
                    fetch_addr_d = {pgm_hi_q, pgm_lo_q, 3'b000};
                end
            end
            ST_ADDR: begin
                m0_arvalid = 1'b1;
                if (M0_AXI4_ARREADY) state_d = ST_DATA;
            end
            ST_DATA: begin
                m0_rready = 1'b1;
                if (M0_AXI4_RVALID) begin
                    data_d  = M0_AXI4_RDATA;
                    state_d = ST_IDLE;
                    // Applied after the W1C above so a simultaneous set wins.
                    if (M0_AXI4_RRESP[1]) raw_d[1] = 1'b1;
                    else                  raw_d[0] = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (nrst) begin
            state_q      <= ST_IDLE;
            msk_q        <= '0;
            raw_q        <= '0;
            pgm_lo_q     <= '0;
            pgm_hi_q     <= '0;
            fetch_addr_q <= '0;
            data_q       <= '0;
            bvalid_q     <= 1'b0;
            bid_q        <= '0;
            rvalid_q     <= 1'b0;
            rid_q        <= '0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            msk_q        <= msk_d;
            raw_q        <= raw_d;
            pgm_lo_q     <= pgm_lo_d;
            pgm_hi_q     <= pgm_hi_d;
            fetch_addr_q <= fetch_addr_d;
            data_q       <= data_d;
            bvalid_q     <= bvalid_d;
            bid_q        <= bid_d;
            rvalid_q     <= rvalid_d;
            rid_q        <= rid_d;
            rdata_q      <= rdata_d;
        end
    end

    assign o_intr = |(raw_q & msk_q);

    assign S0_AXI4_AWREADY = wr_hs;
    assign S0_AXI4_WREADY  = wr_hs;
    assign S0_AXI4_BID     = bid_q;
    assign S0_AXI4_BRESP   = 2'b00;
    assign S0_AXI4_BVALID  = bvalid_q;
    assign S0_AXI4_ARREADY = ~rvalid_q;
    assign S0_AXI4_RID     = rid_q;
    assign S0_AXI4_RDATA   = rdata_q;
    assign S0_AXI4_RRESP   = 2'b00;
    assign S0_AXI4_RLAST   = 1'b1;
    assign S0_AXI4_RVALID  = rvalid_q;

    assign M0_AXI4_AWID    = '0;
    assign M0_AXI4_AWADDR  = '0;
    assign M0_AXI4_AWLEN   = '0;
    assign M0_AXI4_AWSIZE  = '0;
    assign M0_AXI4_AWBURST = '0;
    assign M0_AXI4_AWLOCK  = 1'b0;
    assign M0_AXI4_AWCACHE = '0;
    assign M0_AXI4_AWPROT  = '0;
    assign M0_AXI4_AWVALID = 1'b0;
    assign M0_AXI4_WDATA   = '0;
    assign M0_AXI4_WSTRB   = '0;
    assign M0_AXI4_WLAST   = 1'b0;
    assign M0_AXI4_WVALID  = 1'b0;
    assign M0_AXI4_BREADY  = 1'b1;
    assign M0_AXI4_ARID    = '0;
    assign M0_AXI4_ARADDR  = fetch_addr_q;
    assign M0_AXI4_ARLEN   = 8'd0;
    assign M0_AXI4_ARSIZE  = 3'd3;
    assign M0_AXI4_ARBURST = 2'b01;
    assign M0_AXI4_ARLOCK  = 1'b0;
    assign M0_AXI4_ARCACHE = '0;
    assign M0_AXI4_ARPROT  = '0;
    assign M0_AXI4_ARVALID = m0_arvalid;
    assign M0_AXI4_RREADY  = m0_rready;

    assign M1_AXI4_AWID    = '0;
    assign M1_AXI4_AWADDR  = '0;
    assign M1_AXI4_AWLEN   = '0;
    assign M1_AXI4_AWSIZE  = '0;
    assign M1_AXI4_AWBURST = '0;
    assign M1_AXI4_AWLOCK  = 1'b0;
    assign M1_AXI4_AWCACHE = '0;
    assign M1_AXI4_AWPROT  = '0;
    assign M1_AXI4_AWVALID = 1'b0;
    assign M1_AXI4_WDATA   = '0;
    assign M1_AXI4_WSTRB   = '0;
    assign M1_AXI4_WLAST   = 1'b0;
    assign M1_AXI4_WVALID  = 1'b0;
    assign M1_AXI4_BREADY  = 1'b1;
    assign M1_AXI4_ARID    = '0;
    assign M1_AXI4_ARADDR  = '0;
    assign M1_AXI4_ARLEN   = '0;
    assign M1_AXI4_ARSIZE  = '0;
    assign M1_AXI4_ARBURST = '0;
    assign M1_AXI4_ARLOCK  = 1'b0;
    assign M1_AXI4_ARCACHE = '0;
    assign M1_AXI4_ARPROT  = '0;
    assign M1_AXI4_ARVALID = 1'b0;
    assign M1_AXI4_RREADY  = 1'b1;

    logic unused_inputs;
    assign unused_inputs = ^{S0_AXI4_AWADDR[1:0], S0_AXI4_AWLEN, S0_AXI4_AWSIZE,
                             S0_AXI4_AWBURST, S0_AXI4_AWLOCK, S0_AXI4_AWCACHE,
                             S0_AXI4_AWPROT, S0_AXI4_WSTRB, S0_AXI4_WLAST,
                             S0_AXI4_ARADDR[1:0], S0_AXI4_ARLEN, S0_AXI4_ARSIZE,
                             S0_AXI4_ARBURST, S0_AXI4_ARLOCK, S0_AXI4_ARCACHE,
                             S0_AXI4_ARPROT, M0_AXI4_AWREADY, M0_AXI4_WREADY,
                             M0_AXI4_BID, M0_AXI4_BRESP, M0_AXI4_BVALID,
                             M0_AXI4_RID, M0_AXI4_RRESP[0], M0_AXI4_RLAST,
                             M1_AXI4_AWREADY, M1_AXI4_WREADY, M1_AXI4_BID,
                             M1_AXI4_BRESP, M1_AXI4_BVALID, M1_AXI4_ARREADY,
                             M1_AXI4_RID, M1_AXI4_RDATA, M1_AXI4_RRESP,
                             M1_AXI4_RLAST, M1_AXI4_RVALID,
                             MEMIF_FIFO_DEPTH_POW2[0]};

endmodule

// File: tb/tb_vxe_top.sv
// Directed bench for vxe_top: register access over S0, fetches served by a
// scripted M0 responder, read data checked against an expected queue.
module tb_vxe_top;

    logic clk = 1'b0;
    logic nrst;
    logic o_intr;

    logic [6:0]  S0_AXI4_AWID;
    logic [11:0] S0_AXI4_AWADDR;
    logic        S0_AXI4_AWVALID, S0_AXI4_AWREADY;
    logic [31:0] S0_AXI4_WDATA;
    logic        S0_AXI4_WVALID, S0_AXI4_WREADY;
    logic [6:0]  S0_AXI4_BID;
    logic [1:0]  S0_AXI4_BRESP;
    logic        S0_AXI4_BVALID, S0_AXI4_BREADY;
    logic [6:0]  S0_AXI4_ARID;
    logic [11:0] S0_AXI4_ARADDR;
    logic        S0_AXI4_ARVALID, S0_AXI4_ARREADY;
    logic [6:0]  S0_AXI4_RID;
    logic [31:0] S0_AXI4_RDATA;
    logic [1:0]  S0_AXI4_RRESP;
    logic        S0_AXI4_RLAST, S0_AXI4_RVALID, S0_AXI4_RREADY;

    logic [6:0]  M0_AXI4_AWID, M0_AXI4_BID, M0_AXI4_ARID, M0_AXI4_RID;
    logic [39:0] M0_AXI4_AWADDR, M0_AXI4_ARADDR;
    logic [7:0]  M0_AXI4_AWLEN, M0_AXI4_ARLEN, M0_AXI4_WSTRB;
    logic [2:0]  M0_AXI4_AWSIZE, M0_AXI4_ARSIZE, M0_AXI4_AWPROT, M0_AXI4_ARPROT;
    logic [1:0]  M0_AXI4_AWBURST, M0_AXI4_ARBURST, M0_AXI4_BRESP, M0_AXI4_RRESP;
    logic        M0_AXI4_AWLOCK, M0_AXI4_ARLOCK;
    logic [3:0]  M0_AXI4_AWCACHE, M0_AXI4_ARCACHE;
    logic        M0_AXI4_AWVALID, M0_AXI4_AWREADY, M0_AXI4_WLAST, M0_AXI4_WVALID, M0_AXI4_WREADY;
    logic [63:0] M0_AXI4_WDATA, M0_AXI4_RDATA;
    logic        M0_AXI4_BVALID, M0_AXI4_BREADY, M0_AXI4_ARVALID, M0_AXI4_ARREADY;
    logic        M0_AXI4_RLAST, M0_AXI4_RVALID, M0_AXI4_RREADY;

    logic [6:0]  M1_AXI4_AWID, M1_AXI4_BID, M1_AXI4_ARID, M1_AXI4_RID;
    logic [39:0] M1_AXI4_AWADDR, M1_AXI4_ARADDR;
    logic [7:0]  M1_AXI4_AWLEN, M1_AXI4_ARLEN, M1_AXI4_WSTRB;
    logic [2:0]  M1_AXI4_AWSIZE, M1_AXI4_ARSIZE, M1_AXI4_AWPROT, M1_AXI4_ARPROT;
    logic [1:0]  M1_AXI4_AWBURST, M1_AXI4_ARBURST, M1_AXI4_BRESP, M1_AXI4_RRESP;
    logic        M1_AXI4_AWLOCK, M1_AXI4_ARLOCK;
    logic [3:0]  M1_AXI4_AWCACHE, M1_AXI4_ARCACHE;
    logic        M1_AXI4_AWVALID, M1_AXI4_AWREADY, M1_AXI4_WLAST, M1_AXI4_WVALID, M1_AXI4_WREADY;
    logic [63:0] M1_AXI4_WDATA, M1_AXI4_RDATA;
    logic        M1_AXI4_BVALID, M1_AXI4_BREADY, M1_AXI4_ARVALID, M1_AXI4_ARREADY;
    logic        M1_AXI4_RLAST, M1_AXI4_RVALID, M1_AXI4_RREADY;

    vxe_top dut (
        .clk(clk), .nrst(nrst), .o_intr(o_intr),
        .S0_AXI4_AWID(S0_AXI4_AWID), .S0_AXI4_AWADDR(S0_AXI4_AWADDR),
        .S0_AXI4_AWLEN(8'd0), .S0_AXI4_AWSIZE(3'd2), .S0_AXI4_AWBURST(2'b01),
        .S0_AXI4_AWLOCK(1'b0), .S0_AXI4_AWCACHE(4'd0), .S0_AXI4_AWPROT(3'd0),
        .S0_AXI4_AWVALID(S0_AXI4_AWVALID), .S0_AXI4_AWREADY(S0_AXI4_AWREADY),
        .S0_AXI4_WDATA(S0_AXI4_WDATA), .S0_AXI4_WSTRB(4'hF), .S0_AXI4_WLAST(1'b1),
        .S0_AXI4_WVALID(S0_AXI4_WVALID), .S0_AXI4_WREADY(S0_AXI4_WREADY),
        .S0_AXI4_BID(S0_AXI4_BID), .S0_AXI4_BRESP(S0_AXI4_BRESP),
        .S0_AXI4_BVALID(S0_AXI4_BVALID), .S0_AXI4_BREADY(S0_AXI4_BREADY),
        .S0_AXI4_ARID(S0_AXI4_ARID), .S0_AXI4_ARADDR(S0_AXI4_ARADDR),
        .S0_AXI4_ARLEN(8'd0), .S0_AXI4_ARSIZE(3'd2), .S0_AXI4_ARBURST(2'b01),
        .S0_AXI4_ARLOCK(1'b0), .S0_AXI4_ARCACHE(4'd0), .S0_AXI4_ARPROT(3'd0),
        .S0_AXI4_ARVALID(S0_AXI4_ARVALID), .S0_AXI4_ARREADY(S0_AXI4_ARREADY),
        .S0_AXI4_RID(S0_AXI4_RID), .S0_AXI4_RDATA(S0_AXI4_RDATA),
        .S0_AXI4_RRESP(S0_AXI4_RRESP), .S0_AXI4_RLAST(S0_AXI4_RLAST),
        .S0_AXI4_RVALID(S0_AXI4_RVALID), .S0_AXI4_RREADY(S0_AXI4_RREADY),
        .M0_AXI4_AWID(M0_AXI4_AWID), .M0_AXI4_AWADDR(M0_AXI4_AWADDR),
        .M0_AXI4_AWLEN(M0_AXI4_AWLEN), .M0_AXI4_AWSIZE(M0_AXI4_AWSIZE),
        .M0_AXI4_AWBURST(M0_AXI4_AWBURST), .M0_AXI4_AWLOCK(M0_AXI4_AWLOCK),
        .M0_AXI4_AWCACHE(M0_AXI4_AWCACHE), .M0_AXI4_AWPROT(M0_AXI4_AWPROT),
        .M0_AXI4_AWVALID(M0_AXI4_AWVALID), .M0_AXI4_AWREADY(M0_AXI4_AWREADY),
        .M0_AXI4_WDATA(M0_AXI4_WDATA), .M0_AXI4_WSTRB(M0_AXI4_WSTRB),
        .M0_AXI4_WLAST(M0_AXI4_WLAST), .M0_AXI4_WVALID(M0_AXI4_WVALID),
        .M0_AXI4_WREADY(M0_AXI4_WREADY), .M0_AXI4_BID(M0_AXI4_BID),
        .M0_AXI4_BRESP(M0_AXI4_BRESP), .M0_AXI4_BVALID(M0_AXI4_BVALID),
        .M0_AXI4_BREADY(M0_AXI4_BREADY), .M0_AXI4_ARID(M0_AXI4_ARID),
        .M0_AXI4_ARADDR(M0_AXI4_ARADDR), .M0_AXI4_ARLEN(M0_AXI4_ARLEN),
        .M0_AXI4_ARSIZE(M0_AXI4_ARSIZE), .M0_AXI4_ARBURST(M0_AXI4_ARBURST),
        .M0_AXI4_ARLOCK(M0_AXI4_ARLOCK), .M0_AXI4_ARCACHE(M0_AXI4_ARCACHE),
        .M0_AXI4_ARPROT(M0_AXI4_ARPROT), .M0_AXI4_ARVALID(M0_AXI4_ARVALID),
        .M0_AXI4_ARREADY(M0_AXI4_ARREADY), .M0_AXI4_RID(M0_AXI4_RID),
        .M0_AXI4_RDATA(M0_AXI4_RDATA), .M0_AXI4_RRESP(M0_AXI4_RRESP),
        .M0_AXI4_RLAST(M0_AXI4_RLAST), .M0_AXI4_RVALID(M0_AXI4_RVALID),
        .M0_AXI4_RREADY(M0_AXI4_RREADY),
        .M1_AXI4_AWID(M1_AXI4_AWID), .M1_AXI4_AWADDR(M1_AXI4_AWADDR),
        .M1_AXI4_AWLEN(M1_AXI4_AWLEN), .M1_AXI4_AWSIZE(M1_AXI4_AWSIZE),
        .M1_AXI4_AWBURST(M1_AXI4_AWBURST), .M1_AXI4_AWLOCK(M1_AXI4_AWLOCK),
        .M1_AXI4_AWCACHE(M1_AXI4_AWCACHE), .M1_AXI4_AWPROT(M1_AXI4_AWPROT),
        .M1_AXI4_AWVALID(M1_AXI4_AWVALID), .M1_AXI4_AWREADY(M1_AXI4_AWREADY),
        .M1_AXI4_WDATA(M1_AXI4_WDATA), .M1_AXI4_WSTRB(M1_AXI4_WSTRB),
        .M1_AXI4_WLAST(M1_AXI4_WLAST), .M1_AXI4_WVALID(M1_AXI4_WVALID),
        .M1_AXI4_WREADY(M1_AXI4_WREADY), .M1_AXI4_BID(M1_AXI4_BID),
        .M1_AXI4_BRESP(M1_AXI4_BRESP), .M1_AXI4_BVALID(M1_AXI4_BVALID),
        .M1_AXI4_BREADY(M1_AXI4_BREADY), .M1_AXI4_ARID(M1_AXI4_ARID),
        .M1_AXI4_ARADDR(M1_AXI4_ARADDR), .M1_AXI4_ARLEN(M1_AXI4_ARLEN),
        .M1_AXI4_ARSIZE(M1_AXI4_ARSIZE), .M1_AXI4_ARBURST(M1_AXI4_ARBURST),
        .M1_AXI4_ARLOCK(M1_AXI4_ARLOCK), .M1_AXI4_ARCACHE(M1_AXI4_ARCACHE),
        .M1_AXI4_ARPROT(M1_AXI4_ARPROT), .M1_AXI4_ARVALID(M1_AXI4_ARVALID),
        .M1_AXI4_ARREADY(M1_AXI4_ARREADY), .M1_AXI4_RID(M1_AXI4_RID),
        .M1_AXI4_RDATA(M1_AXI4_RDATA), .M1_AXI4_RRESP(M1_AXI4_RRESP),
        .M1_AXI4_RLAST(M1_AXI4_RLAST), .M1_AXI4_RVALID(M1_AXI4_RVALID),
        .M1_AXI4_RREADY(M1_AXI4_RREADY)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];
    logic [6:0]  exp_id_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic axi_write(input logic [9:0] idx, input logic [31:0] data, input string tag);
        logic [6:0] id;
        int n;
        id = 7'($urandom_range(0, 127));
        S0_AXI4_AWADDR  = {idx, 2'($urandom_range(0, 3))};
        S0_AXI4_AWID    = id;
        S0_AXI4_WDATA   = data;
        S0_AXI4_AWVALID = 1'b1;
        S0_AXI4_WVALID  = 1'b1;
        n = 0;
        @(negedge clk);
        while (!S0_AXI4_AWREADY && n < 50) begin
            n++;
            @(negedge clk);
        end
        check({tag, "_awready"}, {63'h0, S0_AXI4_AWREADY}, 64'h1);
        @(posedge clk);
        #1;
        S0_AXI4_AWVALID = 1'b0;
        S0_AXI4_WVALID  = 1'b0;
        @(negedge clk);
        check({tag, "_bvalid"}, {63'h0, S0_AXI4_BVALID}, 64'h1);
        check({tag, "_bid"}, {57'h0, S0_AXI4_BID}, {57'h0, id});
        @(posedge clk);
        #1;
    endtask

    // Read data is scored against the expected queue when the R beat appears.
    task automatic axi_read(input logic [9:0] idx, input logic [31:0] exp,
                            input logic [6:0] id, input string tag);
        int n;
        logic [31:0] e;
        logic [6:0]  eid;
        exp_q.push_back(exp);
        exp_id_q.push_back(id);
        S0_AXI4_ARADDR  = {idx, 2'($urandom_range(0, 3))};
        S0_AXI4_ARID    = id;
        S0_AXI4_ARVALID = 1'b1;
        n = 0;
        @(negedge clk);
        while (!S0_AXI4_ARREADY && n < 50) begin
            n++;
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        S0_AXI4_ARVALID = 1'b0;
        @(negedge clk);
        check({tag, "_rvalid"}, {63'h0, S0_AXI4_RVALID}, 64'h1);
        e   = exp_q.pop_front();
        eid = exp_id_q.pop_front();
        check({tag, "_rdata"}, {32'h0, S0_AXI4_RDATA}, {32'h0, e});
        check({tag, "_rid"}, {57'h0, S0_AXI4_RID}, {57'h0, eid});
        check({tag, "_rlast_rresp"}, {61'h0, S0_AXI4_RLAST, S0_AXI4_RRESP}, 64'h4);
        @(posedge clk);
        #1;
    endtask

    // Holds ARREADY high for a window and counts how many AR handshakes occur.
    task automatic m0_accept_ar(input string tag);
        int hs;
        hs = 0;
        M0_AXI4_ARREADY = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (M0_AXI4_ARVALID && M0_AXI4_ARREADY) hs++;
        end
        @(posedge clk);
        #1;
        M0_AXI4_ARREADY = 1'b0;
        check({tag, "_ar_handshakes"}, 64'(hs), 64'd1);
    endtask

    task automatic m0_r_beat(input logic [63:0] data, input logic [1:0] resp, input string tag);
        int n;
        M0_AXI4_RDATA  = data;
        M0_AXI4_RRESP  = resp;
        M0_AXI4_RVALID = 1'b1;
        n = 0;
        @(negedge clk);
        while (!M0_AXI4_RREADY && n < 50) begin
            n++;
            @(negedge clk);
        end
        check({tag, "_rready"}, {63'h0, M0_AXI4_RREADY}, 64'h1);
        @(posedge clk);
        #1;
        M0_AXI4_RVALID = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        nrst = 1'b1;
        S0_AXI4_AWID = '0; S0_AXI4_AWADDR = '0; S0_AXI4_AWVALID = 1'b0;
        S0_AXI4_WDATA = '0; S0_AXI4_WVALID = 1'b0; S0_AXI4_BREADY = 1'b1;
        S0_AXI4_ARID = '0; S0_AXI4_ARADDR = '0; S0_AXI4_ARVALID = 1'b0;
        S0_AXI4_RREADY = 1'b1;
        M0_AXI4_AWREADY = 1'b0; M0_AXI4_WREADY = 1'b0; M0_AXI4_BID = '0;
        M0_AXI4_BRESP = '0; M0_AXI4_BVALID = 1'b0; M0_AXI4_ARREADY = 1'b0;
        M0_AXI4_RID = '0; M0_AXI4_RDATA = '0; M0_AXI4_RRESP = '0;
        M0_AXI4_RLAST = 1'b1; M0_AXI4_RVALID = 1'b0;
        M1_AXI4_AWREADY = 1'b0; M1_AXI4_WREADY = 1'b0; M1_AXI4_BID = '0;
        M1_AXI4_BRESP = '0; M1_AXI4_BVALID = 1'b0; M1_AXI4_ARREADY = 1'b0;
        M1_AXI4_RID = '0; M1_AXI4_RDATA = '0; M1_AXI4_RRESP = '0;
        M1_AXI4_RLAST = 1'b0; M1_AXI4_RVALID = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_outputs", {60'h0, o_intr, S0_AXI4_BVALID, S0_AXI4_RVALID, M0_AXI4_ARVALID}, 64'h0);
        check("rst_m0_rready", {63'h0, M0_AXI4_RREADY}, 64'h0);
        check("tieoff_m0", {61'h0, M0_AXI4_AWVALID, M0_AXI4_WVALID, M0_AXI4_BREADY}, 64'h1);
        check("tieoff_m1", {59'h0, M1_AXI4_AWVALID, M1_AXI4_WVALID, M1_AXI4_ARVALID,
                            M1_AXI4_BREADY, M1_AXI4_RREADY}, 64'h3);
        @(posedge clk);
        #1;
        nrst = 1'b0;
        @(posedge clk);
        #1;

        axi_read(10'd0, 32'h5658_4500, 7'h10, "id_reg");
        axi_read(10'd1, 32'h0, 7'h22, "status_idle");
        axi_write(10'd5, 32'h1234_567F, "wr_pgm_lo");
        axi_read(10'd5, 32'h1234_5678, 7'h05, "pgm_lo_rb");
        axi_write(10'd5, 32'h1234_5678, "wr_pgm_lo2");
        axi_write(10'd6, 32'hFFFF_FFAB, "wr_pgm_hi");
        axi_read(10'd6, 32'h0000_00AB, 7'h06, "pgm_hi_rb");
        axi_write(10'd3, 32'h1, "wr_msk1");
        axi_read(10'd3, 32'h1, 7'h03, "msk_rb");

        // First fetch: START while idle, then a second START while still busy.
        axi_write(10'd7, 32'hDEAD_BEEF, "wr_start");
        @(negedge clk);
        check("ar_valid", {63'h0, M0_AXI4_ARVALID}, 64'h1);
        check("ar_addr", {24'h0, M0_AXI4_ARADDR}, 64'h00AB_1234_5678);
        check("ar_len_size_burst", {51'h0, M0_AXI4_ARLEN, M0_AXI4_ARSIZE, M0_AXI4_ARBURST},
              {51'h0, 8'd0, 3'd3, 2'b01});
        check("ar_id_lock_cache_prot", {48'h0, M0_AXI4_ARID, M0_AXI4_ARLOCK, M0_AXI4_ARCACHE,
              M0_AXI4_ARPROT}, 64'h0);
        @(posedge clk);
        #1;
        axi_read(10'd1, 32'h1, 7'h11, "status_busy");
        axi_read(10'd7, 32'h0, 7'h07, "start_reads0");
        axi_write(10'd7, 32'h0, "wr_start_busy");
        m0_accept_ar("fetch1");
        m0_r_beat(64'h0123_4567_89AB_CDEF, 2'b00, "fetch1");
        @(negedge clk);
        check("fetch1_intr", {63'h0, o_intr}, 64'h1);
        check("fetch1_no_refetch", {63'h0, M0_AXI4_ARVALID}, 64'h0);
        @(posedge clk);
        #1;
        axi_read(10'd8, 32'h89AB_CDEF, 7'h08, "data_lo");
        axi_read(10'd9, 32'h0123_4567, 7'h09, "data_hi");
        axi_read(10'd4, 32'h1, 7'h04, "raw_done");
        axi_read(10'd2, 32'h1, 7'h02, "act_done");
        axi_read(10'd1, 32'h0, 7'h01, "status_done");
        axi_write(10'd2, 32'h1, "w1c_done");
        axi_read(10'd4, 32'h0, 7'h14, "raw_cleared");
        @(negedge clk);
        check("intr_cleared", {63'h0, o_intr}, 64'h0);
        @(posedge clk);
        #1;

        // Error fetch with the interrupt masked, then unmasked.
        axi_write(10'd3, 32'h0, "wr_msk0");
        axi_write(10'd7, 32'h1, "wr_start2");
        m0_accept_ar("fetch2");
        m0_r_beat(64'hFEDC_BA98_7654_3210, 2'b10, "fetch2");
        axi_read(10'd4, 32'h2, 7'h24, "raw_err");
        @(negedge clk);
        check("err_masked_intr", {63'h0, o_intr}, 64'h0);
        @(posedge clk);
        #1;
        axi_write(10'd3, 32'h2, "wr_msk2");
        @(negedge clk);
        check("err_unmasked_intr", {63'h0, o_intr}, 64'h1);
        @(posedge clk);
        #1;
        axi_read(10'd2, 32'h2, 7'h12, "act_err");
        axi_read(10'd9, 32'hFEDC_BA98, 7'h19, "data_hi2");
        axi_write(10'd0, 32'hFFFF_FFFF, "wr_id_ro");
        axi_read(10'd0, 32'h5658_4500, 7'h20, "id_unchanged");
        axi_write(10'd12, 32'hFFFF_FFFF, "wr_unmapped");
        axi_read(10'd12, 32'h0, 7'h0C, "rd_unmapped");
        axi_read(10'd1023, 32'h0, 7'h7F, "rd_top_index");

        // Reset while the fetch waits in DATA; a late beat must be ignored.
        axi_write(10'd7, 32'h0, "wr_start3");
        m0_accept_ar("fetch3");
        @(negedge clk);
        check("fetch3_in_data", {63'h0, M0_AXI4_RREADY}, 64'h1);
        @(posedge clk);
        #1;
        nrst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        nrst = 1'b0;
        @(negedge clk);
        check("midrst_m0", {62'h0, M0_AXI4_ARVALID, M0_AXI4_RREADY}, 64'h0);
        check("midrst_intr", {63'h0, o_intr}, 64'h0);
        @(posedge clk);
        #1;
        M0_AXI4_RDATA  = 64'hAAAA_BBBB_CCCC_DDDD;
        M0_AXI4_RRESP  = 2'b00;
        M0_AXI4_RVALID = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("late_beat_rready%0d", i), {63'h0, M0_AXI4_RREADY}, 64'h0);
        end
        @(posedge clk);
        #1;
        M0_AXI4_RVALID = 1'b0;
        axi_read(10'd1, 32'h0, 7'h31, "midrst_status");
        axi_read(10'd8, 32'h0, 7'h38, "midrst_data_lo");
        axi_read(10'd9, 32'h0, 7'h39, "midrst_data_hi");
        axi_read(10'd4, 32'h0, 7'h34, "midrst_raw");
        axi_read(10'd3, 32'h0, 7'h33, "midrst_msk");

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, observed running expected done");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/vxe_top.md
VXE_TOP -- requirements
Module: vxe_top

Interface
REQ-001 The block SHALL have exactly one clock and a synchronous, active-high reset: ports clk and nrst, reset asserted while nrst=1 at a rising clk edge.
REQ-002 Parameters, one per line (name, default, meaning):
- S0_ID_WIDTH, 7, slave ID width.
- M0_ID_WIDTH, 7, master-0 ID width.
- M1_ID_WIDTH, 7, master-1 ID width.
- MEMIF_FIFO_DEPTH_POW2, 5, log2 of the memory-IF FIFO depth; accepted for compatibility and unused.
REQ-003 Ports, one per line (name, direction, width, meaning):
- clk, in, 1, clock.
- nrst, in, 1, synchronous active-high reset.
- o_intr, out, 1, interrupt.
- S0_AXI4_AW*/W*/B*/AR*/R*, slave, full AXI4 set: ADDR 12 bits, DATA 32 bits, STRB 4 bits, IDs S0_ID_WIDTH; LEN/SIZE/BURST/LOCK/CACHE/PROT/STRB inputs accepted and ignored.
- M0_AXI4_*, master, full AXI4 set: ADDR 40 bits, DATA 64 bits, STRB 8 bits, IDs M0_ID_WIDTH.
- M1_AXI4_*, master, same set as M0 with IDs M1_ID_WIDTH.

Function
REQ-004 Register index = S0 ADDR[11:2]; ADDR[1:0] ignored; every access is single-beat 32-bit.
REQ-005 Register map:
- 0 ID, RO = 0x56584500.
- 1 STATUS, RO, bit0 = busy.
- 2 INTR_ACT, RO = RAW&MSK; writing 1 to a bit clears that RAW bit.
- 3 INTR_MSK, RW [1:0].
- 4 INTR_RAW, RO [1:0]: bit0 done, bit1 error.
- 5 PGM_LO, RW [31:3]; [2:0] read 0.
- 6 PGM_HI, RW [7:0].
- 7 START, WO; reads 0.
- 8 DATA_LO, RO.
- 9 DATA_HI, RO.
- Other indices read 0; writes to them are ignored.
REQ-006 Slave write path:
- AWREADY = WREADY = AWVALID & WVALID & ~BVALID, combinational.
- The register update occurs on that handshake edge.
- BVALID rises on the next cycle with BID = captured AWID and BRESP = 00.
- BVALID holds until BREADY.
REQ-007 Slave read path:
- ARREADY = ~RVALID.
- On handshake, RVALID rises on the next cycle with RDATA = register value, RID = ARID, RRESP = 00, RLAST = 1.
- RVALID holds until RREADY.
- Read and write paths operate independently and concurrently.
REQ-008 START behaviour:
- A START write while idle enters state ADDR and sets busy.
- A START write while busy is ignored.
- The written data value is irrelevant.
REQ-009 Fetch FSM, states IDLE -> ADDR -> DATA -> IDLE:
- ADDR: M0 ARVALID = 1, held until ARREADY, then go to DATA.
- DATA: M0 RREADY = 1; on RVALID, capture RDATA into DATA_HI:DATA_LO and return to IDLE.
REQ-010 M0 read request fields:
- ARADDR = {PGM_HI, PGM_LO[31:3], 3'b000}.
- ARLEN = 0, ARSIZE = 3, ARBURST = 01, ARID = 0.
- ARLOCK = 0, ARCACHE = 0, ARPROT = 0.
- Address fields stay stable while ARVALID = 1.
REQ-011 Fetch completion:
- RRESP[1] = 0 sets RAW bit0; RRESP[1] = 1 sets RAW bit1.
- busy clears in the same cycle.
- If a set and a W1C hit the same bit in the same cycle, the set wins.
REQ-012 o_intr = |(INTR_RAW & INTR_MSK), from registered state, with no combinational path from bus inputs.
REQ-013 Tie-offs:
- M0 AWVALID and WVALID = 0; BREADY = 1; write fields = 0.
- M1 AWVALID, WVALID and ARVALID = 0; BREADY = 1; RREADY = 1; all other outputs = 0.

Reset
REQ-014 While nrst = 1 at a clk edge, the following clear to 0 on that edge, and the FSM returns to IDLE:
- all registers;
- S0 BVALID and RVALID;
- M0 ARVALID and RREADY;
- o_intr.
REQ-015 Reset asserted mid-fetch abandons the transaction; a late M0 R beat arriving after reset is ignored.

Verification
REQ-016 Hold nrst = 1 for 3 cycles, release, then read index 0 -> RVALID exactly one cycle after the AR handshake, RDATA = 0x56584500, RID = 0x10, RLAST = 1.
REQ-017 Write PGM_LO = 0x12345678 and PGM_HI = 0xAB, then write START:
- expect M0 ARVALID one cycle later with ARADDR = 0xAB12345678, ARLEN = 0, ARSIZE = 3;
- STATUS reads 1.
REQ-018 With MSK = 1, return M0 RDATA = 0x0123456789ABCDEF with RRESP = 00 ->
- DATA_LO = 0x89ABCDEF, DATA_HI = 0x01234567;
- RAW = 1, o_intr = 1;
- writing 1 to INTR_ACT clears RAW to 0 and o_intr to 0.
REQ-019 A fetch with RRESP = 10 and MSK = 0 -> RAW = 2, o_intr = 0; then writing MSK = 2 -> o_intr = 1.
REQ-020 A START written while busy, with M0 ARREADY held 0, produces exactly one AR handshake once ARREADY = 1.
REQ-021 Assert nrst = 1 during DATA, then release -> FSM idle, busy = 0, and a returned R beat leaves DATA_LO/DATA_HI and RAW unchanged.
